// File: rtl/acknak_replay_ctrl.sv
// Transmit-side Ack/Nak controller: sequence assignment, DLLP window check, purge/replay commands,
// replay timer and REPLAY_NUM rollover. Define ACKNAK_STATS_EN to add Nak/timeout statistics counters.
module acknak_replay_ctrl #(
  parameter int SEQ_W          = 12,
  parameter int TIMER_W        = 16,
  parameter int REPLAY_TIMEOUT = 711,
  parameter int MAX_REPLAY     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [SEQ_W-1:0] next_tx_seq,
  input  logic             dllp_valid,
  input  logic             dllp_is_nak,
  input  logic [SEQ_W-1:0] dllp_seq,
  input  logic             buf_full,
  input  logic             buf_rdy,
  output logic [1:0]       rd,
  output logic [SEQ_W-1:0] purge_count,
  output logic [SEQ_W-1:0] num_packets_to_replay,
  output logic [SEQ_W-1:0] ackd_seq,
  output logic             tim_out,
  output logic             replay_rollover,
  output logic             dllp_err
`ifdef ACKNAK_STATS_EN
  ,
  output logic [15:0]      nak_count,
  output logic [15:0]      timeout_count
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PURGE    = 2'd1;
  localparam logic [1:0] ST_REPLAY   = 2'd2;
  localparam logic [1:0] ST_WAIT_RDY = 2'd3;

  localparam int RN_W = (MAX_REPLAY < 1) ? 1 : $clog2(MAX_REPLAY + 1);
  localparam logic [SEQ_W-1:0] WIN_LIMIT = SEQ_W'((1 << (SEQ_W - 1)) - 1);

  logic [1:0]         state_r;
  logic [TIMER_W-1:0] timer_r;
  logic [RN_W-1:0]    replay_num_r;
  logic               ready_en_r;
  logic               nak_after_purge_r;
  logic               pend_vld_r;
  logic               pend_nak_r;
  logic [SEQ_W-1:0]   pend_seq_r;

  logic [SEQ_W-1:0]   outstanding_s;
  logic [SEQ_W-1:0]   delta_s;
  logic               tx_acc_s;
  logic               chk_vld_s;
  logic               chk_nak_s;
  logic [SEQ_W-1:0]   chk_seq_s;
  logic               chk_err_s;
  logic               do_purge_s;
  logic               do_nak0_s;
  logic               count_s;
  logic               expire_s;

  assign outstanding_s = next_tx_seq - SEQ_W'(1) - ackd_seq;
  assign tx_ready      = ready_en_r & (state_r == ST_IDLE) & ~buf_full & (outstanding_s < WIN_LIMIT);
  assign tx_acc_s      = tx_valid & tx_ready;

  // A live DLLP strobe supersedes whatever is waiting in the pending slot.
  always_comb begin
    chk_vld_s = 1'b0;
    chk_nak_s = 1'b0;
    chk_seq_s = {SEQ_W{1'b0}};
    if (dllp_valid) begin
      chk_vld_s = 1'b1;
      chk_nak_s = dllp_is_nak;
      chk_seq_s = dllp_seq;
    end else if (pend_vld_r) begin
      chk_vld_s = 1'b1;
      chk_nak_s = pend_nak_r;
      chk_seq_s = pend_seq_r;
    end else begin
      chk_vld_s = 1'b0;
    end
  end

  assign delta_s    = chk_seq_s - ackd_seq;
  assign chk_err_s  = chk_vld_s & (delta_s > outstanding_s);
  assign do_purge_s = chk_vld_s & ~chk_err_s & (delta_s != {SEQ_W{1'b0}});
  assign do_nak0_s  = chk_vld_s & ~chk_err_s & (delta_s == {SEQ_W{1'b0}}) & chk_nak_s;
  assign count_s    = (outstanding_s != {SEQ_W{1'b0}});
  assign expire_s   = count_s & (timer_r == TIMER_W'(REPLAY_TIMEOUT - 1));

  // Main control FSM, sequence/ack registers, replay timer and buffer command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r               <= ST_IDLE;
      timer_r               <= {TIMER_W{1'b0}};
      replay_num_r          <= {RN_W{1'b0}};
      ready_en_r            <= 1'b0;
      nak_after_purge_r     <= 1'b0;
      pend_vld_r            <= 1'b0;
      pend_nak_r            <= 1'b0;
      pend_seq_r            <= {SEQ_W{1'b0}};
      next_tx_seq           <= {SEQ_W{1'b0}};
      ackd_seq              <= {SEQ_W{1'b1}};
      rd                    <= 2'b00;
      purge_count           <= {SEQ_W{1'b0}};
      num_packets_to_replay <= {SEQ_W{1'b0}};
      tim_out               <= 1'b0;
      replay_rollover       <= 1'b0;
      dllp_err              <= 1'b0;
    end else begin
      ready_en_r      <= 1'b1;
      rd              <= 2'b00;
      tim_out         <= 1'b0;
      replay_rollover <= 1'b0;
      dllp_err        <= 1'b0;

      if (tx_acc_s) begin
        next_tx_seq <= next_tx_seq + SEQ_W'(1);
      end

      if (state_r == ST_IDLE) begin
        pend_vld_r <= 1'b0;
      end else if (dllp_valid) begin
        pend_vld_r <= 1'b1;
        pend_nak_r <= dllp_is_nak;
        pend_seq_r <= dllp_seq;
      end

      case (state_r)
        ST_IDLE: begin
          dllp_err <= chk_err_s;
          // DLLP actions take priority over a coincident timer expiry.
          if (do_purge_s) begin
            rd                <= 2'b01;
            purge_count       <= delta_s;
            ackd_seq          <= chk_seq_s;
            replay_num_r      <= {RN_W{1'b0}};
            timer_r           <= {TIMER_W{1'b0}};
            nak_after_purge_r <= chk_nak_s;
            state_r           <= ST_PURGE;
          end else if (do_nak0_s) begin
            timer_r <= {TIMER_W{1'b0}};
            state_r <= ST_REPLAY;
          end else if (expire_s) begin
            tim_out <= 1'b1;
            timer_r <= {TIMER_W{1'b0}};
            state_r <= ST_REPLAY;
          end else if (count_s) begin
            timer_r <= timer_r + TIMER_W'(1);
          end else begin
            timer_r <= {TIMER_W{1'b0}};
          end
        end
        ST_PURGE: begin
          timer_r <= {TIMER_W{1'b0}};
          state_r <= nak_after_purge_r ? ST_REPLAY : ST_IDLE;
        end
        ST_REPLAY: begin
          timer_r <= {TIMER_W{1'b0}};
          if (outstanding_s == {SEQ_W{1'b0}}) begin
            state_r <= ST_IDLE;
          end else begin
            rd                    <= 2'b10;
            num_packets_to_replay <= outstanding_s;
            if (replay_num_r == RN_W'(MAX_REPLAY)) begin
              replay_num_r    <= {RN_W{1'b0}};
              replay_rollover <= 1'b1;
            end else begin
              replay_num_r <= replay_num_r + RN_W'(1);
            end
            state_r <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          timer_r <= {TIMER_W{1'b0}};
          if (buf_rdy) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ACKNAK_STATS_EN
  logic nak_replay_s;

  assign nak_replay_s = ((state_r == ST_IDLE) & do_nak0_s) | ((state_r == ST_PURGE) & nak_after_purge_r);

  // Saturating statistics: Naks that lead to a replay, and replay-timer expiries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nak_count     <= 16'h0000;
      timeout_count <= 16'h0000;
    end else begin
      if (nak_replay_s && (nak_count != 16'hFFFF)) begin
        nak_count <= nak_count + 16'h0001;
      end
      if (tim_out && (timeout_count != 16'hFFFF)) begin
        timeout_count <= timeout_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: doc/acknak_replay_ctrl.md
Name: acknak_replay_ctrl

Overview:
Transmit-side Ack/Nak controller that sits directly upstream of the replay buffer FIFO and drives its rd command, sequence and replay-count inputs. It assigns 12-bit sequence numbers to outgoing TLPs and checks received Ack/Nak DLLPs against the outstanding window. It issues purge and replay commands to the buffer, and it runs the replay timer and the REPLAY_NUM rollover counter.

Parameters:
SEQ_W, 12, sequence-number width; all sequence arithmetic is modulo 2^SEQ_W.
TIMER_W, 16, replay-timer width.
REPLAY_TIMEOUT, 711, timer terminal count in clk cycles.
MAX_REPLAY, 3, replays allowed before a rollover is flagged.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
tx_valid  in  1  TLP written to replay buffer this cycle, using next_tx_seq
tx_ready  out  1  controller accepts tx_valid
next_tx_seq  out  SEQ_W  sequence number for the next TLP
dllp_valid  in  1  received Ack/Nak DLLP strobe
dllp_is_nak  in  1  1 = Nak, 0 = Ack
dllp_seq  in  SEQ_W  AckNak_Seq_Num
buf_full  in  1  replay buffer full
buf_rdy  in  1  replay buffer finished replay (pulse)
rd  out  2  buffer command: 00 idle, 01 purge, 10 replay
purge_count  out  SEQ_W  entries to purge, valid with rd=01
num_packets_to_replay  out  SEQ_W  entries to replay, valid with rd=10
ackd_seq  out  SEQ_W  last acknowledged sequence number
tim_out  out  1  replay-timer expiry pulse
replay_rollover  out  1  REPLAY_NUM rollover pulse (link retrain request)
dllp_err  out  1  DLLP sequence outside window (pulse)

Behaviour:
- Reset values: next_tx_seq=0, ackd_seq=all-ones, rd=00, purge_count=0, num_packets_to_replay=0, tim_out=0, replay_rollover=0, dllp_err=0, tx_ready=0 while in reset, timer=0, replay_num=0, state=IDLE.
- Outstanding count: outstanding = (next_tx_seq - 1 - ackd_seq) mod 2^SEQ_W.
- tx_ready = state==IDLE & ~buf_full & outstanding < 2^(SEQ_W-1)-1.
- Accepted tx: tx_valid & tx_ready increments next_tx_seq with wrap (FFF to 000).
- DLLP check: delta = (dllp_seq - ackd_seq) mod 2^SEQ_W.
  - delta > outstanding: pulse dllp_err one cycle after the strobe; the DLLP is otherwise ignored.
  - Ack with delta=0: duplicate; no action.
- FSM states: IDLE, PURGE, REPLAY, WAIT_RDY.
- IDLE → PURGE: on a valid DLLP with delta>0.
  - Next cycle: rd=01 for exactly one cycle, purge_count=delta, ackd_seq←dllp_seq, replay_num←0, timer←0.
- PURGE exit: Ack returns to IDLE; Nak goes to REPLAY.
- IDLE → REPLAY: on Nak with delta=0, or on timer expiry.
- REPLAY: if the outstanding count after any purge is 0, return to IDLE with no command. Otherwise:
  - Drive rd=10 for one cycle, with num_packets_to_replay = that count.
  - Increment replay_num. If replay_num was MAX_REPLAY, instead clear it and pulse replay_rollover in the same cycle; the replay still issues.
  - Go to WAIT_RDY.
- WAIT_RDY: the timer is held at 0. On buf_rdy, return to IDLE and restart the timer.
  - DLLPs arriving in PURGE/REPLAY/WAIT_RDY go to a one-deep pending slot; a newer DLLP overwrites it.
  - The pending DLLP is processed on the first IDLE cycle, re-checked against the current window.
- Timer: counts only in IDLE while outstanding>0; held at 0 when outstanding=0.
  - At REPLAY_TIMEOUT: pulse tim_out one cycle, enter REPLAY.
- Simultaneous events:
  - tx and DLLP in the same cycle: the DLLP check uses the pre-increment next_tx_seq; both take effect.
  - DLLP and timer expiry in the same cycle: the DLLP wins. Ack purge resets the timer; Nak produces exactly one replay. tim_out is not asserted in either case.
- Reset mid-operation: all state returns to reset values immediately; the pending DLLP is discarded.

Optional Feature:
- Macro ACKNAK_STATS_EN.
- Defined: adds outputs nak_count[15:0] and timeout_count[15:0], saturating at FFFF and cleared by rst_n.
  - nak_count increments per Nak that reaches REPLAY.
  - timeout_count increments per tim_out pulse.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, send 5 TLPs, then Ack seq=2 → rd=01 for one cycle, purge_count=3, ackd_seq=2, next_tx_seq=5.
- After that, Nak seq=2 → no purge; rd=10 for one cycle, num_packets_to_replay=2. Hold buf_rdy low 10 cycles → rd stays 00, tx_ready=0. buf_rdy pulse → IDLE.
- 3 TLPs with no Ack → tim_out at cycle 711 of outstanding>0, rd=10 with count 3. Repeat 4 expiries → 4th asserts replay_rollover with the replay.
- Ack seq=9 with next_tx_seq=5, ackd_seq=2 → dllp_err pulse; no rd activity, ackd_seq unchanged.
- Preload next_tx_seq=FFE, send 4 TLPs (wraps to 002), Ack seq=000 → purge_count=3 relative to ackd_seq=FFD; Ack seq=001 → purge_count=1.
- Nak issued while in WAIT_RDY, rst_n low mid-replay → all outputs at reset values asynchronously; no pending DLLP processed after release.
